// File: rtl/ysyx_23060124__axi_burst_sram_if.sv
// AXI4 slave bus bundle for the burst SRAM: AR/R read channels and
// AW/W/B write channels. The slave modport is the memory side.
interface ysyx_23060124__axi_burst_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [3:0]              S_AXI_ARID;
  logic [7:0]              S_AXI_ARLEN;
  logic [2:0]              S_AXI_ARSIZE;
  logic [1:0]              S_AXI_ARBURST;

  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;
  logic [3:0]              S_AXI_RID;
  logic                    S_AXI_RLAST;

  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [3:0]              S_AXI_AWID;
  logic [7:0]              S_AXI_AWLEN;
  logic [2:0]              S_AXI_AWSIZE;
  logic [1:0]              S_AXI_AWBURST;

  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic                    S_AXI_WLAST;

  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [3:0]              S_AXI_BID;

  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RID, S_AXI_RLAST,
    input  S_AXI_RREADY,
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, S_AXI_BID,
    input  S_AXI_BREADY
  );

  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, S_AXI_RID, S_AXI_RLAST,
    output S_AXI_RREADY,
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID, S_AXI_BID,
    output S_AXI_BREADY
  );
endinterface

// File: rtl/ysyx_23060124__axi_burst_sram.sv
// AXI4 incrementing-burst SRAM slave. Independent read and write engines
// share one word-addressed memory. Reads start after a fixed latency and
// stream without bubbles; out-of-range or malformed requests answer SLVERR.
module ysyx_23060124__axi_burst_sram #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 256,
  parameter int RD_LATENCY = 2
) (
  input logic clk,
  input logic rst_n_sync,
  ysyx_23060124__axi_burst_sram_if.slave s_axi
);

  localparam int WA_W   = ADDR_WIDTH - 2;
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  // Word addresses carry one spare top bit so incrementing never wraps back into range.
  localparam logic [WA_W:0] MEM_LIMIT = (WA_W + 1)'(MEM_WORDS);
  localparam logic [WA_W:0] WA_ONE    = {{WA_W{1'b0}}, 1'b1};
  localparam logic [3:0]    LAT_INIT  = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  r_state_e              r_state_q, r_state_d;
  logic [WA_W:0]         r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [3:0]            r_id_q, r_id_d;
  logic                  r_err_q, r_err_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  r_load;
  logic                  r_beat_ok;

  w_state_e              w_state_q, w_state_d;
  logic [WA_W:0]         w_addr_q, w_addr_d;
  logic [3:0]            w_id_q, w_id_d;
  logic                  w_err_q, w_err_d;
  logic                  w_sticky_q, w_sticky_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_ARADDR[1:0], s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_AWLEN};

  assign s_axi.S_AXI_ARREADY = (r_state_q == R_IDLE);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RID     = r_id_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
  assign s_axi.S_AXI_AWREADY = (w_state_q == W_IDLE);
  assign s_axi.S_AXI_WREADY  = (w_state_q == W_DATA);
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_BID     = w_id_q;
  assign mem_idx             = w_addr_q[IDX_W-1:0];

  // Read engine: accept AR, count down latency, then stream beats fetched at load time.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_id_d    = r_id_q;
    r_err_d   = r_err_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    r_load    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID) begin
          r_addr_d  = {1'b0, s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:2]};
          r_len_d   = s_axi.S_AXI_ARLEN;
          r_id_d    = s_axi.S_AXI_ARID;
          r_err_d   = (s_axi.S_AXI_ARBURST != 2'b01) || (s_axi.S_AXI_ARSIZE != 3'b010);
          r_cnt_d   = LAT_INIT;
          r_beat_d  = 8'd0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) begin
          r_load    = 1'b1;
          r_state_d = R_BURST;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_BURST: begin
        if (s_axi.S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d = r_addr_q + WA_ONE;
            r_beat_d = r_beat_q + 8'd1;
            r_load   = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_beat_ok = !r_err_q && (r_addr_d < MEM_LIMIT);
    if (r_load) begin
      rvalid_d = 1'b1;
      rlast_d  = (r_beat_d == r_len_q);
      rresp_d  = r_beat_ok ? 2'b00 : 2'b10;
      rdata_d  = r_beat_ok ? mem[r_addr_d[IDX_W-1:0]] : '0;
    end
  end

  // Read engine registers; reset drops any beat in flight immediately.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_id_q    <= '0;
      r_err_q   <= 1'b0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_id_q    <= r_id_d;
      r_err_q   <= r_err_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // Write engine: accept AW, commit or drop each W beat, then hold the B response.
  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_id_d     = w_id_q;
    w_err_d    = w_err_q;
    w_sticky_d = w_sticky_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi.S_AXI_AWVALID) begin
          w_addr_d  = {1'b0, s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:2]};
          w_id_d    = s_axi.S_AXI_AWID;
          w_err_d   = (s_axi.S_AXI_AWBURST != 2'b01) || (s_axi.S_AXI_AWSIZE != 3'b010);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.S_AXI_WVALID) begin
          if (!w_err_q && (w_addr_q < MEM_LIMIT)) begin
            mem_we = 1'b1;
          end else begin
            w_sticky_d = 1'b1;
          end
          w_addr_d = w_addr_q + WA_ONE;
          if (s_axi.S_AXI_WLAST) begin
            bvalid_d  = 1'b1;
            bresp_d   = w_sticky_d ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          w_sticky_d = 1'b0;
          w_state_d  = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine registers.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_id_q     <= '0;
      w_err_q    <= 1'b0;
      w_sticky_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_id_q     <= w_id_d;
      w_err_q    <= w_err_d;
      w_sticky_q <= w_sticky_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Byte-masked memory write; storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) begin
          mem[mem_idx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060124__axi_burst_sram.sv
// Self-checking bench for the AXI burst SRAM: directed writes, a table of
// read vectors with hand-computed beats, a stalled long burst, and a
// reset that lands in the middle of a read burst.
module tb_ysyx_23060124__axi_burst_sram;

  logic clk = 1'b0;
  logic rst_n_sync;

  always #5 clk = ~clk;

  ysyx_23060124__axi_burst_sram_if bus ();

  ysyx_23060124__axi_burst_sram dut (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .s_axi      (bus.slave)
  );

  typedef struct packed {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [3:0]       id;
    logic [1:0]       burst;
    logic [2:0]       size;
    logic             stall;
    logic [3:0][31:0] exp_data;
    logic [3:0][1:0]  exp_resp;
  } rd_vec_t;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_buf  [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_count;
  int          rd_latency;
  rd_vec_t     vecs [6];

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic rd_vec_t mk_vec(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                                     input logic [1:0] burst, input logic [2:0] size, input logic stall,
                                     input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                     input logic [31:0] d3, input logic [1:0] r0, input logic [1:0] r1,
                                     input logic [1:0] r2, input logic [1:0] r3);
    rd_vec_t v;
    v.addr = addr; v.len = len; v.id = id; v.burst = burst; v.size = size; v.stall = stall;
    v.exp_data[0] = d0; v.exp_data[1] = d1; v.exp_data[2] = d2; v.exp_data[3] = d3;
    v.exp_resp[0] = r0; v.exp_resp[1] = r1; v.exp_resp[2] = r2; v.exp_resp[3] = r3;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write transaction from wr_buf, checking the B response.
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input int nbeats,
                           input logic [3:0] strb, input logic [2:0] size, input logic [1:0] exp_bresp,
                           input string tag);
    int t;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWID    = id;
    bus.S_AXI_AWLEN   = 8'(nbeats - 1);
    bus.S_AXI_AWSIZE  = size;
    bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!bus.S_AXI_AWREADY && t < 50) begin tick(); t++; end
    checkOutput($sformatf("%s awready", tag), 32'(bus.S_AXI_AWREADY), 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.S_AXI_WDATA  = wr_buf[i];
      bus.S_AXI_WSTRB  = strb;
      bus.S_AXI_WLAST  = (i == nbeats - 1);
      bus.S_AXI_WVALID = 1'b1;
      t = 0;
      while (!bus.S_AXI_WREADY && t < 50) begin tick(); t++; end
      checkOutput($sformatf("%s wready beat%0d", tag, i), 32'(bus.S_AXI_WREADY), 32'd1);
      tick();
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    t = 0;
    while (!bus.S_AXI_BVALID && t < 50) begin tick(); t++; end
    checkOutput($sformatf("%s bvalid", tag), 32'(bus.S_AXI_BVALID), 32'd1);
    checkOutput($sformatf("%s bresp", tag), 32'(bus.S_AXI_BRESP), 32'(exp_bresp));
    checkOutput($sformatf("%s bid", tag), 32'(bus.S_AXI_BID), 32'(id));
    tick();
    bus.S_AXI_BREADY = 1'b0;
    checkOutput($sformatf("%s bvalid after handshake", tag), 32'(bus.S_AXI_BVALID), 32'd0);
  endtask

  // Full read transaction; beats land in rd_* arrays, stalls are checked for stability.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [1:0] burst, input logic [2:0] size, input logic stall,
                          input string tag);
    int          cyc;
    int          p;
    bit          done;
    bit          prev_stalled;
    logic [31:0] prev_data;
    logic        prev_last;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARLEN   = len;
    bus.S_AXI_ARID    = id;
    bus.S_AXI_ARBURST = burst;
    bus.S_AXI_ARSIZE  = size;
    bus.S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!bus.S_AXI_ARREADY && cyc < 50) begin tick(); cyc++; end
    checkOutput($sformatf("%s arready", tag), 32'(bus.S_AXI_ARREADY), 32'd1);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    cyc = 0;
    while (!bus.S_AXI_RVALID && cyc < 40) begin tick(); cyc++; end
    rd_latency   = cyc;
    rd_count     = 0;
    p            = 0;
    done         = 0;
    prev_stalled = 0;
    prev_data    = '0;
    prev_last    = 1'b0;
    while (!done && cyc < 400) begin
      if (prev_stalled) begin
        checkOutput($sformatf("%s stall rdata", tag), bus.S_AXI_RDATA, prev_data);
        checkOutput($sformatf("%s stall rlast", tag), 32'(bus.S_AXI_RLAST), 32'(prev_last));
      end
      prev_stalled = 0;
      if (bus.S_AXI_RVALID) begin
        bus.S_AXI_RREADY = stall ? (p % 3 == 0) : 1'b1;
        p++;
        if (bus.S_AXI_RREADY) begin
          if (rd_count < 16) begin
            rd_data[rd_count] = bus.S_AXI_RDATA;
            rd_resp[rd_count] = bus.S_AXI_RRESP;
            rd_last[rd_count] = bus.S_AXI_RLAST;
            rd_id[rd_count]   = bus.S_AXI_RID;
          end
          rd_count++;
          if (bus.S_AXI_RLAST) done = 1;
        end else begin
          prev_stalled = 1;
          prev_data    = bus.S_AXI_RDATA;
          prev_last    = bus.S_AXI_RLAST;
        end
      end else begin
        bus.S_AXI_RREADY = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.S_AXI_RREADY = 1'b0;
    checkOutput($sformatf("%s completed", tag), 32'(done), 32'd1);
    checkOutput($sformatf("%s rvalid after last", tag), 32'(bus.S_AXI_RVALID), 32'd0);
    checkOutput($sformatf("%s arready after last", tag), 32'(bus.S_AXI_ARREADY), 32'd1);
  endtask

  // Run one table read vector and compare every beat against the table.
  task automatic applyStimulus(input rd_vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    axi_read(v.addr, v.len, v.id, v.burst, v.size, v.stall, tag);
    checkOutput($sformatf("%s beats", tag), 32'(rd_count), 32'(v.len) + 32'd1);
    checkOutput($sformatf("%s latency", tag), 32'(rd_latency), 32'd2);
    for (int b = 0; b <= int'(v.len) && b < 4; b++) begin
      checkOutput($sformatf("%s b%0d rdata", tag, b), rd_data[b], v.exp_data[b]);
      checkOutput($sformatf("%s b%0d rresp", tag, b), 32'(rd_resp[b]), 32'(v.exp_resp[b]));
      checkOutput($sformatf("%s b%0d rlast", tag, b), 32'(rd_last[b]), 32'(b == int'(v.len)));
      checkOutput($sformatf("%s b%0d rid", tag, b), 32'(rd_id[b]), 32'(v.id));
    end
  endtask

  // Values expected on every output while reset is held.
  task automatic check_reset_outputs(input string tag);
    checkOutput($sformatf("%s arready", tag), 32'(bus.S_AXI_ARREADY), 32'd1);
    checkOutput($sformatf("%s awready", tag), 32'(bus.S_AXI_AWREADY), 32'd1);
    checkOutput($sformatf("%s rvalid", tag), 32'(bus.S_AXI_RVALID), 32'd0);
    checkOutput($sformatf("%s rlast", tag), 32'(bus.S_AXI_RLAST), 32'd0);
    checkOutput($sformatf("%s rresp", tag), 32'(bus.S_AXI_RRESP), 32'd0);
    checkOutput($sformatf("%s rdata", tag), bus.S_AXI_RDATA, 32'd0);
    checkOutput($sformatf("%s rid", tag), 32'(bus.S_AXI_RID), 32'd0);
    checkOutput($sformatf("%s wready", tag), 32'(bus.S_AXI_WREADY), 32'd0);
    checkOutput($sformatf("%s bvalid", tag), 32'(bus.S_AXI_BVALID), 32'd0);
    checkOutput($sformatf("%s bresp", tag), 32'(bus.S_AXI_BRESP), 32'd0);
    checkOutput($sformatf("%s bid", tag), 32'(bus.S_AXI_BID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hs;
    int t;

    vecs[0] = mk_vec(32'h10, 8'd3, 4'h3, 2'b01, 3'b010, 1'b0,
                     32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[1] = mk_vec(32'h40, 8'd0, 4'h4, 2'b01, 3'b010, 1'b0,
                     32'hFF22FF44, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
    vecs[2] = mk_vec(32'h3F8, 8'd3, 4'h6, 2'b01, 3'b010, 1'b0,
                     32'hB0, 32'hC0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b10, 2'b10);
    vecs[3] = mk_vec(32'h10, 8'd1, 4'h7, 2'b10, 3'b010, 1'b0,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b10, 2'b00, 2'b00);
    vecs[4] = mk_vec(32'h10, 8'd0, 4'h8, 2'b01, 3'b001, 1'b0,
                     32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00);
    vecs[5] = mk_vec(32'h14, 8'd1, 4'h1, 2'b01, 3'b010, 1'b1,
                     32'hA1, 32'hA2, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);

    rst_n_sync        = 1'b0;
    bus.S_AXI_ARADDR  = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARID = '0;
    bus.S_AXI_ARLEN   = '0; bus.S_AXI_ARSIZE  = 3'b010; bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_RREADY  = 1'b0;
    bus.S_AXI_AWADDR  = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWID = '0;
    bus.S_AXI_AWLEN   = '0; bus.S_AXI_AWSIZE  = 3'b010; bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_WDATA   = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST   = 1'b0; bus.S_AXI_BREADY = 1'b0;

    #12;
    check_reset_outputs("reset");
    #3;
    rst_n_sync = 1'b1;
    tick();

    wr_buf[0] = 32'hA0; wr_buf[1] = 32'hA1; wr_buf[2] = 32'hA2; wr_buf[3] = 32'hA3;
    axi_write(32'h10, 4'h5, 4, 4'hF, 3'b010, 2'b00, "w_a0");
    wr_buf[0] = 32'hFFFFFFFF;
    axi_write(32'h40, 4'h2, 1, 4'hF, 3'b010, 2'b00, "w_ones");
    wr_buf[0] = 32'h11223344;
    axi_write(32'h40, 4'h3, 1, 4'b0101, 3'b010, 2'b00, "w_strb");
    wr_buf[0] = 32'hB0; wr_buf[1] = 32'hB1;
    axi_write(32'h3F8, 4'h4, 2, 4'hF, 3'b010, 2'b00, "w_top");
    wr_buf[0] = 32'hC0; wr_buf[1] = 32'hC1;
    axi_write(32'h3FC, 4'h6, 2, 4'hF, 3'b010, 2'b10, "w_overrun");
    wr_buf[0] = 32'h0000DEAD;
    axi_write(32'h10, 4'hA, 1, 4'hF, 3'b001, 2'b10, "w_badsize");
    wr_buf[0] = 32'hA4; wr_buf[1] = 32'hA5; wr_buf[2] = 32'hA6; wr_buf[3] = 32'hA7;
    axi_write(32'h20, 4'hB, 4, 4'hF, 3'b010, 2'b00, "w_a4");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], i);
    end

    axi_read(32'h10, 8'd7, 4'h9, 2'b01, 3'b010, 1'b1, "long_stall");
    checkOutput("long_stall beats", 32'(rd_count), 32'd8);
    for (int b = 0; b < 8; b++) begin
      checkOutput($sformatf("long_stall b%0d rdata", b), rd_data[b], 32'hA0 + 32'(b));
      checkOutput($sformatf("long_stall b%0d rlast", b), 32'(rd_last[b]), 32'(b == 7));
    end

    bus.S_AXI_ARADDR  = 32'h10;
    bus.S_AXI_ARLEN   = 8'd7;
    bus.S_AXI_ARID    = 4'hC;
    bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_ARSIZE  = 3'b010;
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    hs = 0;
    t  = 0;
    while (!(bus.S_AXI_RVALID && hs == 2) && t < 50) begin
      if (bus.S_AXI_RVALID) hs++;
      tick();
      t++;
    end
    checkOutput("midreset beat2 rdata", bus.S_AXI_RDATA, 32'hA2);
    #2;
    rst_n_sync = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.S_AXI_RREADY = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n_sync = 1'b1;
    tick();
    checkOutput("post reset arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    checkOutput("post reset rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    applyStimulus(vecs[0], 10);
    applyStimulus(vecs[1], 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
